// File: rtl/wb_regfile.sv
// Writeback stage: selects the retiring value by opcode, commits it to a 16x16
// register file with bypassed read ports, and latches HLT to freeze state.
module wb_regfile #(
  parameter int NREG = 16,
  parameter int DW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_RegWrite,
  input  logic                     wb_MemtoReg,
  input  logic [$clog2(NREG)-1:0]  wb_RegRd,
  input  logic [3:0]               wb_Opcode,
  input  logic [DW-1:0]            wb_alu_data,
  input  logic [DW-1:0]            wb_lw_data,
  input  logic [DW-1:0]            wb_pc_inc,
  input  logic [7:0]               wb_imm8,
  input  logic                     wb_halt,
  input  logic [$clog2(NREG)-1:0]  rd_addr1,
  input  logic [$clog2(NREG)-1:0]  rd_addr2,
  output logic [DW-1:0]            rd_data1,
  output logic [DW-1:0]            rd_data2,
  output logic [DW-1:0]            wr_data,
  output logic                     halted,
  output logic [15:0]              wb_count
);

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [15:0]   wb_count_q;
  logic [DW-1:0] stored_rd;
  logic          commit;

  // Halt state machine: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Halt state machine: next state. HALTED is only left through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && wb_halt) state_d = HALTED;
  end

  // Halt state machine: outputs.
  always_comb begin
    halted = (state_q == HALTED);
  end

  // LLB/LHB merge into the stored (not bypassed) destination value.
  always_comb begin
    stored_rd = (wb_RegRd == '0) ? '0 : regs_q[wb_RegRd];
    case (wb_Opcode)
      OP_LW:   wr_data = wb_MemtoReg ? wb_lw_data : wb_alu_data;
      OP_PCS:  wr_data = wb_pc_inc;
      OP_LLB:  wr_data = {stored_rd[DW-1:8], wb_imm8};
      OP_LHB:  wr_data = {wb_imm8, stored_rd[7:0]};
      default: wr_data = wb_alu_data;
    endcase
  end

  assign commit = wb_RegWrite && (wb_RegRd != '0) && !halted;

  // NOTE: the register array is cleared by the async reset because the
  // architecture guarantees all registers read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      wb_count_q <= '0;
    end else if (commit) begin
      regs_q[wb_RegRd] <= wr_data;
      wb_count_q       <= wb_count_q + 16'd1;
    end
  end

  assign wb_count = wb_count_q;

  // Write-before-read bypass so decode sees this cycle's commit.
  always_comb begin
    if (rd_addr1 == '0)                        rd_data1 = '0;
    else if (commit && rd_addr1 == wb_RegRd)   rd_data1 = wr_data;
    else                                       rd_data1 = regs_q[rd_addr1];
  end

  always_comb begin
    if (rd_addr2 == '0)                        rd_data2 = '0;
    else if (commit && rd_addr2 == wb_RegRd)   rd_data2 = wr_data;
    else                                       rd_data2 = regs_q[rd_addr2];
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register for the 16-bit, 16-register CPU. It takes the registered MEM/WB outputs and selects the writeback value by opcode, including read-modify-write for LLB/LHB. It commits that value into a 16×16 register file and serves the decode stage through two bypassed read ports. It also latches the retiring HLT so that no architectural state changes after halt, and counts committed writes for debug.

## Interface
Parameters:
- NREG, 16, number of architectural registers; register 0 reads as zero and ignores writes.
- DW, 16, data width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- wb_RegWrite  in  1  MEM/WB RegWrite.
- wb_MemtoReg  in  1  MEM/WB MemtoReg.
- wb_RegRd  in  4  destination register.
- wb_Opcode  in  4  retiring opcode.
- wb_alu_data  in  16  ALU result.
- wb_lw_data  in  16  load data.
- wb_pc_inc  in  16  PC+2 of the retiring instruction.
- wb_imm8  in  8  8-bit immediate.
- wb_halt  in  1  retiring instruction is HLT.
- rd_addr1, rd_addr2  in  4 each  decode read addresses.
- rd_data1, rd_data2  out  16 each  read data, combinational, bypassed.
- wr_data  out  16  selected writeback value, combinational; used by the forwarding path.
- halted  out  1  sticky halt flag.
- wb_count  out  16  committed-write counter.

## Operation
- Writeback select on wb_Opcode:
  - 4'b1000 (LW): wb_lw_data if wb_MemtoReg=1, otherwise wb_alu_data.
  - 4'b1110 (PCS): wb_pc_inc.
  - 4'b1010 (LLB): {R[wb_RegRd][15:8], wb_imm8}.
  - 4'b1011 (LHB): {wb_imm8, R[wb_RegRd][7:0]}.
  - All other opcodes: wb_alu_data.
- LLB/LHB read the stored value of R[wb_RegRd], not a bypassed value; R0 reads as 0 here too.
- Commit condition: wb_RegWrite=1, wb_RegRd≠0, and halted=0. On commit, R[wb_RegRd] takes wr_data at the clock edge and wb_count increments by 1, wrapping 16'hFFFF→0.
- Read ports:
  - rd_dataN = 0 if rd_addrN=0.
  - Otherwise rd_dataN = wr_data if the commit condition holds and rd_addrN=wb_RegRd (write-before-read bypass).
  - Otherwise rd_dataN = R[rd_addrN].
- Halt state machine, two states:
  - RUN (halted=0) → HALTED on a rising edge with wb_halt=1.
  - HALTED persists until rst.
- An instruction retiring in the same cycle as HLT commits normally; HLT itself carries RegWrite=0.
- In HALTED: no register writes, wb_count frozen, bypass disabled, read ports return stored values.

## Timing
- Reset (rst=0, asynchronous): all R[i]=0, halted=0, wb_count=0. Outputs reflect this immediately, without waiting for a clock edge. Reset asserted mid-write discards that write.
- Reset release: the first rising edge with rst=1 may commit.
- Write latency: 1 edge. Same-cycle reads see the new value through the bypass; R[] holds it after the edge.
- halted rises on the edge that samples wb_halt=1, and suppresses commits from the following cycle on.
- Both read ports may address the same register, or wb_RegRd, simultaneously; both see identical bypassed data.
- No handshake. Every cycle's MEM/WB contents are consumed; a bubble is RegWrite=0.

## Test plan
- Reset: drive rst=0 mid-simulation after writes → all reads return 0, halted=0, wb_count=0, with no clock edge needed.
- Basic commit and bypass:
  - Opcode 0000, Rd=3, alu_data=16'h1234, RegWrite=1, rd_addr1=3 → rd_data1=16'h1234 in the same cycle and after the edge; wb_count=1.
- LW vs ALU select:
  - Opcode 1000, MemtoReg=1, lw_data=16'hBEEF, alu_data=16'h0002, Rd=5 → R5=16'hBEEF.
  - Same stimulus with MemtoReg=0 → R5=16'h0002.
- LLB/LHB:
  - R7=16'hA5A5, then LLB with imm8=8'h3C → R7=16'hA53C.
  - Then LHB with imm8=8'h11 → R7=16'h113C.
  - PCS with pc_inc=16'h0042 into Rd=2 → R2=16'h0042.
- R0 protection: RegWrite=1, Rd=0, alu_data=16'hFFFF → rd_data1(addr 0)=0, wb_count unchanged.
- Halt and wrap:
  - Preload wb_count=16'hFFFF via 65535 writes; one more write → wb_count=0.
  - Assert wb_halt → halted=1.
  - Subsequent RegWrite=1, Rd=4, data=16'h9999 → R4 unchanged, no bypass, wb_count frozen.
